// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding, port ids,
// wait-counter width and the latched transaction descriptor.
package mem_bus_arbiter_pkg;

  localparam int WAIT_W = 4;

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_ACCESS = 1'b1;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef logic [WAIT_W-1:0] wait_t;

  // Everything the FSM needs to remember about the granted access.
  typedef struct packed {
    logic port;
    logic we;
    logic rom;
  } xact_t;

  // Truncate a wait-state parameter to the counter width; writes need at
  // least one WE_bar-low cycle, so they can force a minimum of one.
  function automatic wait_t to_wait(input int cycles, input bit at_least_one);
    wait_t w;
    w = cycles[WAIT_W-1:0];
    if (at_least_one && (w == '0)) begin
      w = wait_t'(1);
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshakes plus the external memory bus of the arbiter.
// slave: the arbiter's view; master: the requesters and memory around it.
interface mem_bus_arbiter_if;

  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;

  logic        d_req;
  logic [15:0] d_addr;
  logic        d_we;
  logic [7:0]  d_wdata;
  logic        d_ack;

  logic [7:0]  rdata;
  logic        rom_wr_err;
  logic        busy;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_drive_bar;
  logic        mem_oe_bar;
  logic        mem_we_bar;
  logic [7:0]  mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output f_ack, d_ack, rdata, rom_wr_err, busy,
           mem_addr, mem_wdata, mem_drive_bar, mem_oe_bar, mem_we_bar
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  f_ack, d_ack, rdata, rom_wr_err, busy,
           mem_addr, mem_wdata, mem_drive_bar, mem_oe_bar, mem_we_bar
  );

endinterface

// File: rtl/mem_bus_arbiter_wait_counter.sv
// mem_wait_counter: loadable 4-bit down-counter with a zero flag; it holds
// at zero rather than wrapping.
module mem_wait_counter
  import mem_bus_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  wait_t load_val,
  input  logic  dec,
  output wait_t count,
  output logic  zero
);

  wait_t count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - wait_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and data ports with per-region wait
// states. Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed data-first priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [15:0] RAM_BASE       = 16'h8000,
  parameter int          ROM_WAIT       = 1,
  parameter int          RAM_READ_WAIT  = 1,
  parameter int          RAM_WRITE_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  bus
);

  localparam wait_t ROM_W    = to_wait(ROM_WAIT, 1'b0);
  localparam wait_t RAM_RD_W = to_wait(RAM_READ_WAIT, 1'b0);
  localparam wait_t RAM_WR_W = to_wait(RAM_WRITE_WAIT, 1'b1);

  logic [0:0]  state_reg, state_next;
  xact_t       xact_reg;
  logic [15:0] mem_addr_reg;
  logic [7:0]  mem_wdata_reg;
  logic        mem_drive_bar_reg;
  logic        mem_oe_bar_reg;
  logic        mem_we_bar_reg;
  logic [7:0]  rdata_reg;
  logic        rom_wr_err_reg;
  logic [1:0]  ack_reg;

  logic        grant_data;
  logic        any_req;
  logic [15:0] sel_addr;
  logic        sel_we;
  logic        sel_rom;
  wait_t       load_val;
  wait_t       wait_count;
  logic        wait_zero;
  logic        start;
  logic        finish;

  assign any_req = bus.f_req | bus.d_req;
  assign start   = (state_reg == STATE_IDLE) && any_req;
  assign finish  = (state_reg == STATE_ACCESS) && wait_zero;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // On a collision the port that did not win last time goes first.
  always_comb begin
    if (bus.d_req && bus.f_req) begin
      grant_data = (last_grant_reg == PORT_FETCH);
    end else begin
      grant_data = bus.d_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= PORT_FETCH;
    end else if (start) begin
      last_grant_reg <= grant_data ? PORT_DATA : PORT_FETCH;
    end
  end
`else
  assign grant_data = bus.d_req;
`endif

  assign sel_addr = grant_data ? bus.d_addr : bus.f_addr;
  assign sel_we   = grant_data & bus.d_we;
  assign sel_rom  = (sel_addr < RAM_BASE);

  always_comb begin
    load_val = RAM_RD_W;
    if (sel_rom) begin
      load_val = ROM_W;
    end else if (sel_we) begin
      load_val = RAM_WR_W;
    end
  end

  mem_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (load_val),
    .dec      ((state_reg == STATE_ACCESS) && !wait_zero),
    .count    (wait_count),
    .zero     (wait_zero)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      STATE_IDLE:   if (start)  state_next = STATE_ACCESS;
      STATE_ACCESS: if (finish) state_next = STATE_IDLE;
      default:      state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= STATE_IDLE;
      xact_reg          <= '0;
      mem_addr_reg      <= 16'h0000;
      mem_wdata_reg     <= 8'h00;
      mem_drive_bar_reg <= 1'b1;
      mem_oe_bar_reg    <= 1'b1;
      mem_we_bar_reg    <= 1'b1;
      rdata_reg         <= 8'h00;
      rom_wr_err_reg    <= 1'b0;
      ack_reg           <= 2'b00;
    end else begin
      state_reg      <= state_next;
      rom_wr_err_reg <= finish && xact_reg.we && xact_reg.rom;
      ack_reg        <= finish ? (xact_reg.port ? 2'b10 : 2'b01) : 2'b00;

      if (start) begin
        xact_reg     <= '{port: grant_data, we: sel_we, rom: sel_rom};
        mem_addr_reg <= sel_addr;
        if (grant_data) begin
          mem_wdata_reg <= bus.d_wdata;
        end
        // A ROM write runs its wait states with the memory untouched.
        mem_oe_bar_reg    <= sel_we;
        mem_drive_bar_reg <= !(sel_we && !sel_rom);
        mem_we_bar_reg    <= !(sel_we && !sel_rom);
      end else if (finish) begin
        mem_oe_bar_reg    <= 1'b1;
        mem_drive_bar_reg <= 1'b1;
        mem_we_bar_reg    <= 1'b1;
        if (!xact_reg.we) begin
          rdata_reg <= bus.mem_rdata;
        end
      end else if ((state_reg == STATE_ACCESS) && (wait_count == wait_t'(1))) begin
        // Release WE_bar one cycle early so the data is held past the strobe.
        mem_we_bar_reg <= 1'b1;
      end
    end
  end

  assign bus.busy          = (state_reg == STATE_ACCESS);
  assign bus.f_ack         = ack_reg[PORT_FETCH];
  assign bus.d_ack         = ack_reg[PORT_DATA];
  assign bus.rom_wr_err    = rom_wr_err_reg;
  assign bus.rdata         = rdata_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.mem_wdata     = mem_wdata_reg;
  assign bus.mem_drive_bar = mem_drive_bar_reg;
  assign bus.mem_oe_bar    = mem_oe_bar_reg;
  assign bus.mem_we_bar    = mem_we_bar_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter with default parameters: vector table plus
// hand sequences for reset, collisions and a dropped request.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: ROM content is a fixed function of the address, RAM is an array.
  logic [7:0] ram [0:32767];
  bit         rom_hit;

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h38;
  endfunction

  assign bus.mem_rdata = bus.mem_oe_bar ? 8'h00 :
                         (bus.mem_addr < 16'h8000) ? rom_val(bus.mem_addr) :
                         ram[bus.mem_addr[14:0]];

  always @(posedge clk) begin
    if (!bus.mem_we_bar && !bus.mem_drive_bar) begin
      if (bus.mem_addr < 16'h8000) rom_hit <= 1'b1;
      else ram[bus.mem_addr[14:0]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    bit        port;
    logic [7:0] rdata;
    bit        err;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard: every ACK pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (bus.f_ack || bus.d_ack)) begin
      checks++;
      if (bus.f_ack && bus.d_ack) begin
        errors++;
        $display("FAIL dual_ack got f_ack=1 d_ack=1 want one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack got f_ack=%0b d_ack=%0b want none", bus.f_ack, bus.d_ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.d_ack !== e.port || bus.rdata !== e.rdata || bus.rom_wr_err !== e.err) begin
          errors++;
          $display("FAIL sb_ack got port=%0b rdata=%02h err=%0b want port=%0b rdata=%02h err=%0b",
                   bus.d_ack, bus.rdata, bus.rom_wr_err, e.port, e.rdata, e.err);
        end else begin
          $display("ack port=%0b rdata=%02h err=%0b", bus.d_ack, bus.rdata, bus.rom_wr_err);
        end
      end
    end
    if (!rst && bus.rom_wr_err && !bus.d_ack) begin
      checks++;
      errors++;
      $display("FAIL rom_err_alone got rom_wr_err=1 d_ack=0 want d_ack=1");
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_f_ack"},  32'(bus.f_ack), 0);
    check_val({tag, "_d_ack"},  32'(bus.d_ack), 0);
    check_val({tag, "_romerr"}, 32'(bus.rom_wr_err), 0);
    check_val({tag, "_busy"},   32'(bus.busy), 0);
    check_val({tag, "_rdata"},  32'(bus.rdata), 0);
    check_val({tag, "_addr"},   32'(bus.mem_addr), 0);
    check_val({tag, "_wdata"},  32'(bus.mem_wdata), 0);
    check_val({tag, "_drive"},  32'(bus.mem_drive_bar), 1);
    check_val({tag, "_oe"},     32'(bus.mem_oe_bar), 1);
    check_val({tag, "_we"},     32'(bus.mem_we_bar), 1);
  endtask

  typedef struct {
    string      name;
    bit         port;
    bit         we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    bit         exp_err;
    int         exp_lat;
    int         exp_oe;
    int         exp_we;
  } vec_t;

  vec_t vecs[8];

  task automatic do_xact(input vec_t v, output int lat, output int oe_cnt, output int we_cnt);
    bit done;
    exp_q.push_back('{port: v.port, rdata: v.exp_rdata, err: v.exp_err});
    @(posedge clk); #1;
    if (v.port) begin
      bus.d_req = 1'b1; bus.d_addr = v.addr; bus.d_we = v.we; bus.d_wdata = v.wdata;
    end else begin
      bus.f_req = 1'b1; bus.f_addr = v.addr;
    end
    lat = 0; oe_cnt = 0; we_cnt = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.mem_oe_bar) oe_cnt++;
      if (!bus.mem_we_bar) we_cnt++;
      if (v.port ? bus.d_ack : bus.f_ack) begin
        done = 1'b1;
        check_val({v.name, "_busy_at_ack"}, 32'(bus.busy), 0);
      end
    end
    bus.d_req = 1'b0;
    bus.f_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, oe_cnt, we_cnt, n, guard;
    bit order[4];
    bit exp_order[4];

    vecs[0] = '{"f_rom_rd",   0, 0, 16'h0004, 8'h00, 8'h3C, 0, 3, 2, 0};
    vecs[1] = '{"d_ram_wr",   1, 1, 16'h8000, 8'hA5, 8'h3C, 0, 4, 0, 2};
    vecs[2] = '{"d_ram_rd",   1, 0, 16'h8000, 8'h00, 8'hA5, 0, 3, 2, 0};
    vecs[3] = '{"d_rom_wr",   1, 1, 16'h0100, 8'h11, 8'hA5, 1, 3, 0, 0};
    vecs[4] = '{"d_rom_rd",   1, 0, 16'h0100, 8'h00, 8'h39, 0, 3, 2, 0};
    vecs[5] = '{"d_top_wr",   1, 1, 16'hFFFF, 8'h5A, 8'h39, 0, 4, 0, 2};
    vecs[6] = '{"f_top_rd",   0, 0, 16'hFFFF, 8'h00, 8'h5A, 0, 3, 2, 0};
    vecs[7] = '{"d_romtop_rd",1, 0, 16'h7FFF, 8'h00, 8'hB8, 0, 3, 2, 0};

    bus.f_req = 1'b0; bus.f_addr = 16'h0000;
    bus.d_req = 1'b0; bus.d_addr = 16'h0000; bus.d_we = 1'b0; bus.d_wdata = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_xact(vecs[i], lat, oe_cnt, we_cnt);
      $display("xact %s lat=%0d oe=%0d we=%0d", vecs[i].name, lat, oe_cnt, we_cnt);
      check_val({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check_val({vecs[i].name, "_oe_cycles"}, 32'(oe_cnt), 32'(vecs[i].exp_oe));
      check_val({vecs[i].name, "_we_cycles"}, 32'(we_cnt), 32'(vecs[i].exp_we));
    end
    check_val("rom_untouched", 32'(rom_hit), 0);

    // Reset in the middle of a RAM write, with one wait state left.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 16'h8010; bus.d_we = 1'b1; bus.d_wdata = 8'hC3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("midwr_we_low", 32'(bus.mem_we_bar), 0);
    rst = 1'b1;
    #1;
    check_reset_state("midwr");
    bus.d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("midwr_idle_busy", 32'(bus.busy), 0);

    // Collision: both ports held; D dropped after its third turn.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{port: exp_order[i], rdata: exp_order[i] ? 8'hA5 : 8'h3C, err: 1'b0});
    end
    @(posedge clk); #1;
    bus.f_req = 1'b1; bus.f_addr = 16'h0004;
    bus.d_req = 1'b1; bus.d_addr = 16'h8000; bus.d_we = 1'b0;
    n = 0; guard = 0;
    while (n < 4 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
      if (bus.f_ack || bus.d_ack) begin
        order[n] = bus.d_ack;
        n++;
        if (n == 3) bus.d_req = 1'b0;
        if (n == 4) bus.f_req = 1'b0;
      end
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    check_val("collide_count", 32'(n), 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("collide_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    end

    // Fetch request held for a single cycle still completes.
    exp_q.push_back('{port: 1'b0, rdata: 8'h3C, err: 1'b0});
    @(posedge clk); #1;
    bus.f_req = 1'b1; bus.f_addr = 16'h0004;
    @(posedge clk); #1;
    bus.f_req = 1'b0;
    lat = 1;
    while (!bus.f_ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("drop_lat", 32'(lat), 3);
    @(posedge clk); #1;
    check_val("drop_ack_pulse", 32'(bus.f_ack), 0);
    check_val("drop_busy1", 32'(bus.busy), 0);
    @(posedge clk); #1;
    check_val("drop_busy2", 32'(bus.busy), 0);

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
